orb_frame_sequencer: RTL and testbench
======================================

ORB_FRAME_SEQUENCER -- requirements
Module: orb_frame_sequencer

Interface
REQ-001 SHALL have parameters H_ACTIVE, default 720, active pixels per line; V_ACTIVE, default 480, active lines per frame; CORE_LAT, default 4 (range 1..16), ORB core pipeline depth in core_ce cycles; DW, default 32, AXIS data width.
REQ-002 SHALL use one clock, axi_Mclk; reset is synchronous and active-high, named reset.
REQ-003 SHALL have ports: axi_Mclk in 1, clock; reset in 1, sync active-high reset; start in 1, single-cycle frame request pulse; abort in 1, single-cycle abort pulse.
REQ-004 SHALL have ports: s_axis_data in DW, input pixel; s_axis_valid in 1; s_axis_ready out 1; s_axis_last in 1, end of line marker.
REQ-005 SHALL have ports: m_axis_data out DW, processed pixel; m_axis_valid out 1; m_axis_ready in 1; m_axis_last out 1, end of frame marker.
REQ-006 SHALL have ports: core_rst out 1, ORB core reset; core_ce out 1, core pipeline advance; core_din out DW; core_dout in DW; hs_cnt out 10 and vs_cnt out 10, input pixel position; frame_done out 1, interrupt pulse; busy out 1; line_err out 1, sticky; state out 3.

Function
REQ-007 SHALL implement states IDLE(0), FLUSH(1), RUN(2), DRAIN(3), DONE(4); state output equals the encoding.
REQ-008 IDLE: start -> FLUSH; all handshakes low; core_rst high.
REQ-009 FLUSH: core_rst high for exactly CORE_LAT+2 cycles, then -> RUN; hs_cnt, vs_cnt, in-flight register and output counter cleared on entry.
REQ-010 RUN/DRAIN: out_ok = !m_axis_valid || m_axis_ready; core_rst low.
REQ-011 RUN: s_axis_ready = out_ok; core_ce = s_axis_valid && out_ok; core_din = s_axis_data combinationally.
REQ-012 DRAIN: s_axis_ready low; core_ce = out_ok; remaining in-flight slots fed with zero data, valid bit 0.
REQ-013 SHALL keep a CORE_LAT-bit in-flight shift register; on core_ce shift in (RUN ? s_axis_valid : 0); m_axis_valid = MSB; m_axis_data = core_dout; register holds when core_ce low.
REQ-014 On each accepted input beat hs_cnt increments; at hs_cnt == H_ACTIVE-1 it wraps to 0 and vs_cnt increments.
REQ-015 Accepted beat with hs_cnt == H_ACTIVE-1 and vs_cnt == V_ACTIVE-1 -> DRAIN next cycle; counters hold.
REQ-016 s_axis_last on an accepted beat SHALL equal (hs_cnt == H_ACTIVE-1); mismatch sets line_err; line_err cleared only by reset or start; counting continues regardless.
REQ-017 Output counter increments per m_axis handshake; m_axis_last high exactly on output beat H_ACTIVE*V_ACTIVE-1.
REQ-018 DRAIN -> DONE on handshake of the last output beat; DONE lasts one cycle, frame_done high that cycle only, then -> IDLE.
REQ-019 m_axis_valid, once high, SHALL not drop and m_axis_data/last SHALL not change until m_axis_ready.
REQ-020 abort in FLUSH, RUN or DRAIN -> IDLE next cycle, no frame_done, in-flight data discarded, m_axis_valid low next cycle.
REQ-021 start outside IDLE ignored; start and abort same cycle in IDLE -> abort wins (stay IDLE).
REQ-022 busy high in all states except IDLE.
REQ-023 Output counter width SHALL hold H_ACTIVE*V_ACTIVE-1 (19 bits at defaults); no wrap within a frame.

Reset
REQ-024 reset high SHALL force IDLE regardless of state, counters 0, in-flight register 0, line_err 0.
REQ-025 During and after reset: s_axis_ready 0, m_axis_valid 0, m_axis_last 0, core_ce 0, core_rst 1, frame_done 0, busy 0, state 0.
REQ-026 reset asserted mid-frame SHALL drop all handshakes next edge with no partial frame_done.

Verification
REQ-027 Nominal: start, continuous valid, m_axis_ready=1, H=720 V=480 -> 345600 output beats, m_axis_last on beat 345599 only, frame_done single pulse CORE_LAT+1 to CORE_LAT+3 cycles after last input.
REQ-028 Backpressure: m_axis_ready toggling 1-of-3 random -> no data loss/duplication, data order preserved, s_axis_ready low whenever m_axis_valid && !m_axis_ready.
REQ-029 Line marker: H=8 V=4, s_axis_last asserted at hs_cnt 6 of line 2 -> line_err=1, frame still completes with 32 outputs.
REQ-030 Abort: abort at pixel 100 of RUN -> state 0 next cycle, m_axis_valid 0, frame_done never asserted; subsequent start completes a clean frame.
REQ-031 Reset mid-DRAIN -> all outputs at REQ-025 values after one edge; start after reset yields nominal frame.
REQ-032 Boundary: start and abort same cycle in IDLE -> stays IDLE; start during RUN -> ignored, counters unaffected.

Source files
------------

// File: rtl/orb_frame_sequencer_if.sv
// Pixel stream bundle (AXI4-Stream subset) shared by the input and output ports of the sequencer.
interface orb_frame_sequencer_if #(
  parameter int unsigned DW = 32
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/orb_frame_sequencer.sv
// Frame sequencer around an external fixed-latency ORB core: flushes the core, streams one frame
// through it, drains the pipeline and raises a completion pulse.
module orb_frame_sequencer #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CORE_LAT = 4,
  parameter int unsigned DW       = 32
) (
  input  logic                  axi_Mclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  orb_frame_sequencer_if.slave  s_axis,
  orb_frame_sequencer_if.master m_axis,
  output logic                  core_rst,
  output logic                  core_ce,
  output logic [DW-1:0]         core_din,
  input  logic [DW-1:0]         core_dout,
  output logic [9:0]            hs_cnt,
  output logic [9:0]            vs_cnt,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  line_err,
  output logic [2:0]            state
);

  localparam int unsigned Total = H_ACTIVE * V_ACTIVE;
  localparam int unsigned OutW  = (Total > 1) ? $clog2(Total) : 1;
  localparam logic [9:0]      HLast     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      VLast     = 10'(V_ACTIVE - 1);
  localparam logic [OutW-1:0] OutLast   = OutW'(Total - 1);
  localparam logic [4:0]      FlushLast = 5'(CORE_LAT + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFlush = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          flush_q, flush_d;
  logic [9:0]          hs_q, hs_d, vs_q, vs_d;
  logic [CORE_LAT-1:0] inflight_q, inflight_d;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;
  logic                line_err_q, line_err_d;

  logic in_run, in_drain, m_valid, out_ok, in_fire, out_fire, line_end, frame_end;

  assign in_run   = (state_q == StRun);
  assign in_drain = (state_q == StDrain);

  // The MSB of the in-flight register tracks whether the core output slot holds a real pixel.
  assign m_valid  = (in_run || in_drain) && inflight_q[CORE_LAT-1];
  assign out_ok   = !m_valid || m_axis.ready;
  assign in_fire  = s_axis.valid && s_axis.ready;
  assign out_fire = m_valid && m_axis.ready;
  assign line_end  = (hs_q == HLast);
  assign frame_end = line_end && (vs_q == VLast);

  assign s_axis.ready = in_run && out_ok;
  assign m_axis.valid = m_valid;
  assign m_axis.data  = core_dout;
  assign m_axis.last  = m_valid && (out_cnt_q == OutLast);

  assign core_ce  = (in_run && s_axis.valid && out_ok) || (in_drain && out_ok);
  assign core_din = in_run ? s_axis.data : '0;
  assign core_rst = !(in_run || in_drain);

  assign hs_cnt   = hs_q;
  assign vs_cnt   = vs_q;
  assign busy     = (state_q != StIdle);
  assign line_err = line_err_q;
  assign state    = state_q;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    inflight_d = inflight_q;
    out_cnt_d  = out_cnt_q;
    line_err_d = line_err_q;
    frame_done = 1'b0;

    if (core_ce) begin
      inflight_d = (inflight_q << 1) | CORE_LAT'(in_run && s_axis.valid);
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + OutW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StFlush;
          flush_d    = '0;
          hs_d       = '0;
          vs_d       = '0;
          inflight_d = '0;
          out_cnt_d  = '0;
          line_err_d = 1'b0;
        end
      end
      StFlush: begin
        if (flush_q == FlushLast) begin
          state_d = StRun;
        end else begin
          flush_d = flush_q + 5'd1;
        end
      end
      StRun: begin
        if (in_fire) begin
          if (s_axis.last != line_end) begin
            line_err_d = 1'b1;
          end
          // Counters freeze on the final pixel so they still report its position while draining.
          if (frame_end) begin
            state_d = StDrain;
          end else if (line_end) begin
            hs_d = '0;
            vs_d = vs_q + 10'd1;
          end else begin
            hs_d = hs_q + 10'd1;
          end
        end
      end
      StDrain: begin
        if (out_fire && (out_cnt_q == OutLast)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q == StFlush || in_run || in_drain)) begin
      state_d    = StIdle;
      inflight_d = '0;
    end
  end

  always_ff @(posedge axi_Mclk) begin
    if (reset) begin
      state_q    <= StIdle;
      flush_q    <= '0;
      hs_q       <= '0;
      vs_q       <= '0;
      inflight_q <= '0;
      out_cnt_q  <= '0;
      line_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      line_err_q <= line_err_d;
    end
  end

endmodule

// File: tb/tb_orb_frame_sequencer.sv
// Bench for orb_frame_sequencer on an 8x4 frame with a stand-in core that XORs pixels with a key.
module tb_orb_frame_sequencer;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int L     = 4;
  localparam int DW    = 32;
  localparam int Total = H * V;
  localparam logic [31:0] Key = 32'h5A5A_C3C3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort;
  logic        core_rst, core_ce;
  logic [31:0] core_din, core_dout;
  logic [9:0]  hs_cnt, vs_cnt;
  logic        frame_done, busy, line_err;
  logic [2:0]  state;

  orb_frame_sequencer_if #(.DW(DW)) s_if ();
  orb_frame_sequencer_if #(.DW(DW)) m_if ();

  orb_frame_sequencer #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CORE_LAT(L),
    .DW      (DW)
  ) dut (
    .axi_Mclk  (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .core_rst  (core_rst),
    .core_ce   (core_ce),
    .core_din  (core_din),
    .core_dout (core_dout),
    .hs_cnt    (hs_cnt),
    .vs_cnt    (vs_cnt),
    .frame_done(frame_done),
    .busy      (busy),
    .line_err  (line_err),
    .state     (state)
  );

  // Stand-in ORB core: L-deep pipeline that only advances on core_ce.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    if (core_ce) begin
      pipe[0] <= core_din;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign core_dout = pipe[L-1] ^ Key;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: expected output = accepted inputs in order, XOR key; written only below.
  logic [31:0] exp_q [$];
  int          n_acc       = 0;
  int          out_idx     = 0;
  int          done_pulses = 0;
  bit          err_m = 1'b0, done_exp = 1'b0, hold_prev = 1'b0, last_hs, done_next;
  logic [31:0] prev_data, first_data, e;
  logic        prev_last;

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(state != 3'd0));
      chk("frame_done", 64'(frame_done), 64'(done_exp));
      if (frame_done) done_pulses++;
      chk("line_err", 64'(line_err), 64'(err_m));
      if (state inside {3'd1, 3'd2, 3'd3}) begin
        chk("hs_cnt", 64'(hs_cnt), 64'((n_acc >= Total) ? H - 1 : n_acc % H));
        chk("vs_cnt", 64'(vs_cnt), 64'((n_acc >= Total) ? V - 1 : n_acc / H));
      end
      if (m_if.valid && !m_if.ready) chk("s_ready_backpressure", 64'(s_if.ready), 64'(0));
      if (hold_prev) begin
        chk("hold_valid", 64'(m_if.valid), 64'(1));
        chk("hold_data", 64'(m_if.data), 64'(prev_data));
        chk("hold_last", 64'(m_if.last), 64'(prev_last));
      end
      last_hs = 1'b0;
      if (m_if.valid && m_if.ready) begin
        chk("out_beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", 64'(m_if.data), 64'(e));
        end
        chk("m_last", 64'(m_if.last), 64'(out_idx == Total - 1));
        if (out_idx == 0) first_data = m_if.data;
        last_hs = (out_idx == Total - 1);
        out_idx++;
      end

      hold_prev = m_if.valid && !m_if.ready && !reset && !abort;
      prev_data = m_if.data;
      prev_last = m_if.last;
      done_next = 1'b0;
      if (reset) begin
        exp_q.delete();
        n_acc     = 0;
        out_idx   = 0;
        err_m     = 1'b0;
        hold_prev = 1'b0;
      end else if (abort && state inside {3'd1, 3'd2, 3'd3}) begin
        exp_q.delete();
        n_acc     = 0;
        hold_prev = 1'b0;
      end else begin
        if (start && !abort && state == 3'd0) begin
          exp_q.delete();
          n_acc   = 0;
          out_idx = 0;
          err_m   = 1'b0;
        end
        if (s_if.valid && s_if.ready) begin
          if (s_if.last != ((n_acc % H) == H - 1)) err_m = 1'b1;
          exp_q.push_back(s_if.data ^ Key);
          if (n_acc < Total) n_acc++;
        end
        done_next = last_hs;
      end
      done_exp = done_next;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    s_if.valid  = 1'b1;
    m_if.ready  = 1'b1;
    @(negedge clk);
    chk({tag, "_state"}, 64'(state), 64'(0));
    chk({tag, "_s_ready"}, 64'(s_if.ready), 64'(0));
    chk({tag, "_m_valid"}, 64'(m_if.valid), 64'(0));
    chk({tag, "_m_last"}, 64'(m_if.last), 64'(0));
    chk({tag, "_core_ce"}, 64'(core_ce), 64'(0));
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_line_err"}, 64'(line_err), 64'(0));
    s_if.valid = 1'b0;
  endtask

  task automatic run_frame(input int tag, input int bad_idx, input int abort_idx,
                           input int start_idx, input bit bp, input bit rst_drain,
                           input bit timing);
    int idx, flush_cyc, budget, acc_cyc, pulses0, d;
    bit done_seen, pend_run;
    pulses0  = done_pulses;
    pend_run = 1'b0;
    acc_cyc  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0; flush_cyc = 0; budget = 0;
    while (idx < Total && budget < 2000) begin
      s_if.valid = 1'b1;
      s_if.data  = {16'(tag), 16'(idx)};
      s_if.last  = ((idx % H) == H - 1) ^ (idx == bad_idx);
      start      = (idx == start_idx);
      m_if.ready = bp ? ($urandom_range(2, 0) == 0) : 1'b1;
      if (idx == abort_idx) begin
        s_if.valid = 1'b0;
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_state", 64'(state), 64'(0));
        chk("abort_m_valid", 64'(m_if.valid), 64'(0));
        chk("abort_line_err_cleared", 64'(line_err), 64'(0));
        repeat (20) tick();
        chk("abort_no_frame_done", 64'(done_pulses - pulses0), 64'(0));
        return;
      end
      @(negedge clk);
      if (pend_run) begin
        chk("start_in_run_ignored", 64'(state), 64'(2));
        pend_run = 1'b0;
      end
      if (state == 3'd1) flush_cyc++;
      if (s_if.valid && s_if.ready) begin
        acc_cyc = cyc;
        if (idx == start_idx) pend_run = 1'b1;
        idx++;
      end
      budget++;
      tick();
    end
    s_if.valid = 1'b0;
    start = 1'b0;
    chk("inputs_accepted", 64'(idx), 64'(Total));
    chk("flush_cycles", 64'(flush_cyc), 64'(L + 2));
    if (rst_drain) begin
      reset = 1'b1;
      @(negedge clk);
      chk("pre_reset_in_drain", 64'(state), 64'(3));
      tick();
      reset = 1'b0;
      check_quiet("rst_drain");
      tick();
      return;
    end
    done_seen = 1'b0;
    budget = 0;
    while (!done_seen && budget < 200) begin
      m_if.ready = bp ? ($urandom_range(2, 0) == 0) : 1'b1;
      @(negedge clk);
      if (frame_done) begin
        done_seen = 1'b1;
        d = cyc - acc_cyc;
        if (timing) chk("done_latency_window", 64'(d >= L + 1 && d <= L + 3), 64'(1));
      end
      budget++;
      tick();
    end
    m_if.ready = 1'b1;
    chk("frame_done_seen", 64'(done_seen), 64'(1));
    repeat (3) tick();
    chk("frame_done_pulses", 64'(done_pulses - pulses0), 64'(1));
    chk("out_beats", 64'(out_idx), 64'(Total));
  endtask

  initial begin : driver
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) tick();
    check_quiet("in_reset");
    tick();
    reset = 1'b0;
    check_quiet("after_reset");
    tick();

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_state", 64'(state), 64'(0));
    chk("start_abort_busy", 64'(busy), 64'(0));
    tick();

    run_frame(1, -1, -1, 10, 1'b0, 1'b0, 1'b1);
    chk("first_out_frame1", 64'(first_data), 64'(32'h5A5B_C3C3));
    chk("line_err_clean", 64'(line_err), 64'(0));
    run_frame(2, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    run_frame(3, 22, -1, -1, 1'b0, 1'b0, 1'b1);
    chk("line_err_set", 64'(line_err), 64'(1));
    run_frame(4, -1, 20, -1, 1'b0, 1'b0, 1'b0);
    run_frame(5, -1, -1, -1, 1'b0, 1'b0, 1'b1);
    chk("first_out_frame5", 64'(first_data), 64'(32'h5A5F_C3C3));
    run_frame(6, -1, -1, -1, 1'b0, 1'b1, 1'b0);
    run_frame(7, -1, -1, -1, 1'b0, 1'b0, 1'b1);
    chk("first_out_frame7", 64'(first_data), 64'(32'h5A5D_C3C3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
